// File: rtl/des_dec_iter.sv
// Iterative DES decryptor: one Feistel round per clock on a single shared
// round datapath, with subkeys produced in reverse order by right-rotating C/D.
// Handshake: a block is taken on a rising edge where cipher_en=1 and busy=0
// (busy is the inverse of ready); plain_rdy is a one-cycle valid strobe with
// no back-pressure, and plain holds its value until the next completion.
module des_dec_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cipher,
    input  logic        cipher_en,
    input  logic [63:0] key,
    output logic [63:0] plain,
    output logic        plain_rdy,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUND = 1'b1;

    // Permutation tables, DES bit numbers (1 = MSB), first entry in the top byte.
    // Unused trailing bytes are padding and never selected.
    localparam logic [511:0] IP_T = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
    localparam logic [511:0] FP_T = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,  8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,  8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,  8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,  8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
    localparam logic [511:0] E_T = {
        8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
        8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
        8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1, {16{8'd1}}};
    localparam logic [511:0] P_T = {
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,  8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,   8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25, {32{8'd1}}};
    localparam logic [511:0] PC1_T = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,   8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,  8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,  8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,  8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4, {8{8'd1}}};
    localparam logic [511:0] PC2_T = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32, {16{8'd1}}};
    // S1..S8, 64 nibbles each in row-major order (row = outer bits, col = inner bits).
    localparam logic [2047:0] SBOX = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    // Generic DES permutation: m-bit input, n-bit output, both right-aligned.
    function automatic logic [63:0] permute(input logic [63:0] x, input int m, input int n,
                                            input logic [511:0] tbl);
        logic [63:0] res;
        int          t;
        res = '0;
        for (int j = 0; j < 64; j++) begin
            t = int'(tbl[504 - 8*j +: 8]);
            if (j < n) res[n-1-j] = x[m - t];
        end
        return res;
    endfunction

    function automatic logic [31:0] sbox_layer(input logic [47:0] x);
        logic [31:0] res;
        logic [5:0]  b;
        int          e;
        res = '0;
        for (int n = 0; n < 8; n++) begin
            b = x[42 - 6*n +: 6];
            e = int'({b[5], b[0], b[4:1]});
            res[28 - 4*n +: 4] = SBOX[2044 - 256*n - 4*e +: 4];
        end
        return res;
    endfunction

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] l, r;
    logic [27:0] c, d;

    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey, e_out;
    logic [31:0] p_out, r_next;
    logic [63:0] ip_out, fp_out;
    logic [55:0] pc1_out;

    assign busy = (state == ST_ROUND);

    // Round datapath: reverse-order key rotation, f function, and input/output permutations.
    always_comb begin
        case (cnt)
            4'd0:                shift = 2'd0;
            4'd1, 4'd8, 4'd15:   shift = 2'd1;
            default:             shift = 2'd2;
        endcase
        c_rot = c;
        d_rot = d;
        if (shift == 2'd1) begin
            c_rot = {c[0], c[27:1]};
            d_rot = {d[0], d[27:1]};
        end else if (shift == 2'd2) begin
            c_rot = {c[1:0], c[27:2]};
            d_rot = {d[1:0], d[27:2]};
        end
        subkey  = 48'(permute(64'({c_rot, d_rot}), 56, 48, PC2_T));
        e_out   = 48'(permute(64'(r), 32, 48, E_T));
        p_out   = 32'(permute(64'(sbox_layer(e_out ^ subkey)), 32, 32, P_T));
        r_next  = l ^ p_out;
        ip_out  = permute(cipher, 64, 64, IP_T);
        pc1_out = 56'(permute(key, 64, 56, PC1_T));
        fp_out  = permute({r_next, r}, 64, 64, FP_T);
    end

    // Control FSM plus round-state registers; completion swaps halves through FP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            plain     <= '0;
            plain_rdy <= 1'b0;
        end else begin
            plain_rdy <= 1'b0;
            if (state == ST_IDLE) begin
                if (cipher_en) begin
                    {l, r} <= ip_out;
                    {c, d} <= pc1_out;
                    cnt    <= 4'd0;
                    state  <= ST_ROUND;
                end
            end else begin
                l   <= r;
                r   <= r_next;
                c   <= c_rot;
                d   <= d_rot;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    plain     <= fp_out;
                    plain_rdy <= 1'b1;
                    state     <= ST_IDLE;
                end
            end
        end
    end

endmodule
